// File: rtl/conv_pkg.sv
// Shared definitions for the convolutional-code channel stages (serial<->parallel regrouping).
package conv_pkg;

    localparam logic [0:0] S_SEARCH  = 1'b0;
    localparam logic [0:0] S_COLLECT = 1'b1;

    // Symbol width common to the parallel-to-serial and serial-to-parallel stages.
    localparam int unsigned SYMBOL_WIDTH = 2;

endpackage

// File: rtl/serial2parallel.sv
// Serial-to-parallel converter: regroups an LSB-first channel bit stream into WIDTH-bit symbols
// and presents them on a one-entry valid/ready output register with a sticky overflow flag.
module serial2parallel
    import conv_pkg::*;
#(
    parameter int unsigned WIDTH    = SYMBOL_WIDTH,
    parameter bit          ALIGN_EN = 1'b1
) (
    input  logic             clk_sig,
    input  logic             reset_sig,
    input  logic             serial_valid,
    input  logic             serial_sig,
    input  logic             align_sig,
    output logic [WIDTH-1:0] parallel_sig,
    output logic             parallel_valid,
    input  logic             parallel_ready,
    output logic             overflow_sig
);

    localparam int unsigned          CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]     CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [0:0]           S_INIT   = ALIGN_EN ? S_SEARCH : S_COLLECT;

    logic [0:0]       r_state;
    logic [WIDTH-1:0] r_shreg;
    logic [CNT_W-1:0] r_bit_cnt;
    logic [WIDTH-1:0] r_parallel;
    logic             r_valid;
    logic             r_overflow;

    logic [0:0]       w_state_nxt;
    logic [WIDTH-1:0] w_shreg_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_complete;
    logic             w_align;
    logic [WIDTH-1:0] w_shifted;

    assign w_align   = ALIGN_EN & align_sig;
    assign w_shifted = {serial_sig, r_shreg[WIDTH-1:1]};

    // Framing FSM and bit counter next-state; an align bit always restarts the symbol at bit 0.
    always_comb begin
        w_state_nxt = r_state;
        w_shreg_nxt = r_shreg;
        w_cnt_nxt   = r_bit_cnt;
        w_complete  = 1'b0;
        if (serial_valid) begin
            case (r_state)
                S_SEARCH: begin
                    if (w_align) begin
                        w_shreg_nxt = w_shifted;
                        w_cnt_nxt   = CNT_ONE;
                        w_state_nxt = S_COLLECT;
                    end else begin
                        w_state_nxt = S_SEARCH;
                    end
                end
                S_COLLECT: begin
                    w_shreg_nxt = w_shifted;
                    if (w_align && (r_bit_cnt != CNT_ZERO)) begin
                        w_cnt_nxt = CNT_ONE;
                    end else if (r_bit_cnt == CNT_LAST) begin
                        w_cnt_nxt  = CNT_ZERO;
                        w_complete = 1'b1;
                    end else begin
                        w_cnt_nxt = r_bit_cnt + CNT_ONE;
                    end
                end
                default: begin
                    w_state_nxt = S_INIT;
                    w_cnt_nxt   = CNT_ZERO;
                end
            endcase
        end else begin
            w_state_nxt = r_state;
        end
    end

    // Framing state registers.
    always_ff @(posedge clk_sig or negedge reset_sig) begin
        if (!reset_sig) begin
            r_state   <= S_INIT;
            r_shreg   <= '0;
            r_bit_cnt <= CNT_ZERO;
        end else begin
            r_state   <= w_state_nxt;
            r_shreg   <= w_shreg_nxt;
            r_bit_cnt <= w_cnt_nxt;
        end
    end

    // One-entry output register: consume and refill may happen in the same cycle without a bubble.
    always_ff @(posedge clk_sig or negedge reset_sig) begin
        if (!reset_sig) begin
            r_parallel <= '0;
            r_valid    <= 1'b0;
            r_overflow <= 1'b0;
        end else if (w_complete && (!r_valid || parallel_ready)) begin
            r_parallel <= w_shifted;
            r_valid    <= 1'b1;
        end else if (w_complete) begin
            r_overflow <= 1'b1;
        end else if (r_valid && parallel_ready) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= r_valid;
        end
    end

    assign parallel_sig   = r_parallel;
    assign parallel_valid = r_valid;
    assign overflow_sig   = r_overflow;

endmodule
